// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Signal bundle between a push-button source and the button
//               conditioner. The slave modport is the conditioner side.
//   button      : raw asynchronous push-button, active-high (source -> cond.)
//   repeat_en   : 1 = auto-repeat while held              (source -> cond.)
//   valid_pulse : single-cycle strobe per accepted press or repeat
//   level       : debounced button level
//   press_count : running count of valid_pulse strobes, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
  logic       button;
  logic       repeat_en;
  logic       valid_pulse;
  logic       level;
  logic [7:0] press_count;

  modport master (
    output button,
    output repeat_en,
    input  valid_pulse,
    input  level,
    input  press_count
  );

  modport slave (
    input  button,
    input  repeat_en,
    output valid_pulse,
    output level,
    output press_count
  );
endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Turns a raw bouncing push-button into a clean single-cycle
//               valid strobe: two-flop synchronizer, debounce filter,
//               rising-edge one-shot and an optional hold-to-auto-repeat FSM.
//   clk    : system clock, all state on the rising edge
//   rst    : synchronous active-high reset
//   ctl_if : slave side of button_conditioner_if
//            (button, repeat_en in; valid_pulse, level, press_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000,
  parameter int TMR_W           = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  button_conditioner_if.slave    ctl_if
);

  localparam logic [TMR_W-1:0] C_DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] C_PER_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [TMR_W-1:0] deb_tmr_q, deb_tmr_d;
  logic [TMR_W-1:0] rpt_tmr_q, rpt_tmr_d;
  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [7:0]       count_q, count_d;

  logic w_mismatch;
  logic w_toggle;
  logic w_rise;
  logic w_fall;

  // --------------------------------------------------------------------------
  // Debounce: the timer counts consecutive cycles of disagreement between the
  // synchronized input and the stable level; the level flips on the cycle
  // that completes DEBOUNCE_CYCLES of disagreement.
  // --------------------------------------------------------------------------
  assign w_mismatch = sync2_q ^ level_q;
  assign w_toggle   = w_mismatch && (deb_tmr_q == C_DEB_LAST);
  // The FSM reacts on the same edge the level flips, so it uses the flip
  // condition rather than the registered level.
  assign w_rise     = w_toggle & ~level_q;
  assign w_fall     = w_toggle &  level_q;

  always_comb begin
    level_d   = level_q;
    deb_tmr_d = deb_tmr_q;
    if (!w_mismatch) begin
      deb_tmr_d = '0;
    end else if (w_toggle) begin
      level_d   = ~level_q;
      deb_tmr_d = '0;
    end else begin
      deb_tmr_d = deb_tmr_q + C_TMR_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Press / auto-repeat FSM. A release always wins over a coincident repeat
  // expiry, so the release test comes first in the held states.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rpt_tmr_d = rpt_tmr_q;
    valid_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rpt_tmr_d = '0;
        if (w_rise) begin
          valid_d = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          rpt_tmr_d = '0;
          state_d   = ST_IDLE;
        end else if (!ctl_if.repeat_en) begin
          rpt_tmr_d = '0;
        end else if (rpt_tmr_q == C_DLY_LAST) begin
          valid_d   = 1'b1;
          rpt_tmr_d = '0;
          state_d   = ST_REPEAT;
        end else begin
          rpt_tmr_d = rpt_tmr_q + C_TMR_ONE;
        end
      end
      ST_REPEAT: begin
        if (w_fall) begin
          rpt_tmr_d = '0;
          state_d   = ST_IDLE;
        end else if (!ctl_if.repeat_en) begin
          rpt_tmr_d = '0;
          state_d   = ST_HELD;
        end else if (rpt_tmr_q == C_PER_LAST) begin
          valid_d   = 1'b1;
          rpt_tmr_d = '0;
        end else begin
          rpt_tmr_d = rpt_tmr_q + C_TMR_ONE;
        end
      end
      default: begin
        rpt_tmr_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign count_d = valid_d ? (count_q + 8'd1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_tmr_q <= '0;
      rpt_tmr_q <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= ctl_if.button;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_tmr_q <= deb_tmr_d;
      rpt_tmr_q <= rpt_tmr_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign ctl_if.valid_pulse = valid_q;
  assign ctl_if.level       = level_q;
  assign ctl_if.press_count = count_q;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A behavioural
//               model tracks the debounced level as a run length of
//               disagreeing samples and schedules pulses as absolute
//               deadlines (press time + delay, then + period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .TMR_W           (TW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_if (bif)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_s1, m_s2, m_lvl, m_run, m_held, m_deadline, m_pulse, m_cnt;
  int cyc = 0;

  // observation bookkeeping
  int n_pulses  = 0;
  int last_puls = -1;
  int prev_vp   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input int b, input int re, input int r);
    int flip;
    if (r != 0) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_held = 0; m_deadline = 0; m_pulse = 0; m_cnt = 0;
      return;
    end
    flip = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == D) flip = 1;
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
    m_pulse = 0;
    if (flip != 0) begin
      m_run = 0;
      m_lvl = 1 - m_lvl;
      if (m_lvl == 1) begin
        m_pulse    = 1;
        m_held     = 1;
        m_deadline = cyc + RD;
      end else begin
        m_held = 0;
      end
    end else if (m_held != 0) begin
      if (re == 0) begin
        m_deadline = cyc + RD;
      end else if (cyc == m_deadline) begin
        m_pulse    = 1;
        m_deadline = cyc + RP;
      end
    end
    if (m_pulse != 0) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic step(input int b, input int re, input int r);
    bif.button    = b[0];
    bif.repeat_en = re[0];
    rst           = r[0];
    @(posedge clk);
    cyc++;
    model_edge(b, re, r);
    #1;
    chk("valid_pulse", {31'd0, bif.valid_pulse}, m_pulse);
    chk("level", {31'd0, bif.level}, m_lvl);
    chk("press_count", {24'd0, bif.press_count}, m_cnt);
    if (bif.valid_pulse) begin
      chk("no_back_to_back", prev_vp, 0);
      n_pulses++;
      last_puls = cyc;
    end
    prev_vp = int'(bif.valid_pulse);
  endtask

  initial begin
    int t, p0, h, r, c0, rel;
    bif.button    = 1'b0;
    bif.repeat_en = 1'b0;
    model_edge(0, 0, 1);

    // 1. clean press, no repeat
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("reset_level", {31'd0, bif.level}, 0);
    chk("reset_count", {24'd0, bif.press_count}, 0);
    c0 = cyc;
    p0 = n_pulses;
    for (int i = 0; i < 110; i++) step(1, 0, 0);
    chk("clean_press_pulses", n_pulses - p0, 1);
    chk("clean_press_latency", last_puls, c0 + 6);
    chk("clean_press_count", {24'd0, bif.press_count}, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("clean_release_level", {31'd0, bif.level}, 0);

    // 2. bounce rejection, then bounce-into-hold
    step(0, 0, 1);
    p0 = n_pulses;
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0); step(0, 0, 0);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("bounce_no_pulse", n_pulses - p0, 0);
    chk("bounce_count", {24'd0, bif.press_count}, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0); step(0, 0, 0);
    end
    h = cyc + 1;
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("bounce_hold_pulses", n_pulses - p0, 1);
    chk("bounce_hold_latency", last_puls, h + 5);
    for (int i = 0; i < 12; i++) step(0, 0, 0);

    // 3. auto-repeat for 40 cycles after acceptance
    step(0, 1, 1);
    p0 = n_pulses;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      step(1, 1, 0);
      if (bif.valid_pulse) t = cyc;
    end
    chk("repeat_accept_seen", (t >= 0), 1);
    while (cyc < t + 40) step(1, 1, 0);
    chk("repeat_pulses", n_pulses - p0, 8);
    chk("repeat_count", {24'd0, bif.press_count}, 8);
    rel = cyc + 1;
    p0  = n_pulses;
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("repeat_release_level_hold", {31'd0, bif.level}, 1);
    step(0, 1, 0);
    chk("repeat_release_level_fall", {31'd0, bif.level}, 0);
    chk("repeat_release_at", cyc, rel + 5);
    for (int i = 0; i < 10; i++) step(0, 1, 0);

    // 4. release coinciding with repeat expiry at t+15
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      step(1, 1, 0);
      if (bif.valid_pulse) t = cyc;
    end
    while (cyc < t + 9) step(1, 1, 0);
    step(0, 1, 0);
    chk("expiry_pulse_t10", last_puls, t + 10);
    p0 = n_pulses;
    c0 = int'(bif.press_count);
    for (int i = 0; i < 11; i++) step(0, 1, 0);
    chk("expiry_release_no_pulse", n_pulses - p0, 0);
    chk("expiry_release_count", {24'd0, bif.press_count}, c0);
    chk("expiry_release_level", {31'd0, bif.level}, 0);

    // 5. reset in REPEAT with the button held
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      step(1, 1, 0);
      if (bif.valid_pulse) t = cyc;
    end
    while (cyc < t + 12) step(1, 1, 0);
    step(1, 1, 1);
    r = cyc;
    chk("midreset_pulse", {31'd0, bif.valid_pulse}, 0);
    chk("midreset_level", {31'd0, bif.level}, 0);
    chk("midreset_count", {24'd0, bif.press_count}, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("midreset_repress_at", last_puls, r + 6);
    for (int i = 0; i < 12; i++) step(0, 0, 0);

    // 6. 256 presses wrap the counter
    c0 = int'(bif.press_count);
    p0 = n_pulses;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 8; i++) step(1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0);
    end
    chk("wrap_pulses", n_pulses - p0, 256);
    chk("wrap_count", {24'd0, bif.press_count}, c0);

    // 7. randomized runs of button level, repeat_en and occasional reset
    begin
      int b, re, run;
      b = 0; re = 0;
      for (int k = 0; k < 300; k++) begin
        run = int'($urandom_range(1, 30));
        b = 1 - b;
        for (int i = 0; i < run; i++) begin
          if ($urandom_range(0, 15) == 0) re = 1 - re;
          step(b, re, ($urandom_range(0, 400) == 0) ? 1 : 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that turns a raw, asynchronous, bouncing push-button into a clean single-cycle valid strobe.
- Feeds the counter stage's validtocounter input.
- Provides a two-flop synchronizer, a debounce filter, rising-edge one-shot generation and an optional hold-to-auto-repeat FSM.
- Also exposes the debounced level and a running pulse count for observation.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from the stable level before the level flips (>=1).
- REPEAT_DELAY, 50000, cycles from a debounced press until the first auto-repeat pulse (>=2).
- REPEAT_PERIOD, 10000, cycles between subsequent auto-repeat pulses (>=2).
- TMR_W, 20, width of the debounce and repeat timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- button  in  1  raw asynchronous push-button, active-high
- repeat_en  in  1  1 = auto-repeat while held; 0 = one pulse per press
- valid_pulse  out  1  registered single-cycle strobe, one per accepted press or repeat
- level  out  1  registered debounced button level
- press_count  out  8  count of valid_pulse assertions, wraps 255->0

Behaviour:
- Reset: sync flops, level, valid_pulse, debounce timer, repeat timer, press_count all 0; FSM = IDLE. rst has priority over every other event.
- Synchronizer: sync1 <= button; sync2 <= sync1. Only sync2 is used downstream.
- Debounce:
  - If sync2 == level, the timer clears to 0.
  - If sync2 != level, the timer increments.
  - On the edge where the timer == DEBOUNCE_CYCLES-1 and mismatch persists, level toggles and the timer clears.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles changes nothing.
- Latency: button sampled high at edges 1,2,3,... gives level = 1 and valid_pulse = 1 after edge DEBOUNCE_CYCLES+2. Release latency is identical.
- FSM states IDLE, HELD, REPEAT. valid_pulse defaults to 0 every cycle.
- IDLE:
  - On the edge where level rises, assert valid_pulse for one cycle, clear the repeat timer, go to HELD.
- HELD:
  - Repeat timer increments each cycle.
  - If repeat_en = 1 and the timer reaches REPEAT_DELAY-1, assert valid_pulse, clear the timer, go to REPEAT.
  - If repeat_en = 0, the timer holds at 0 and the FSM stays in HELD.
- REPEAT:
  - Timer increments.
  - At REPEAT_PERIOD-1, assert valid_pulse and clear the timer.
  - If repeat_en falls, go to HELD with the timer cleared; no pulse.
- Release: in HELD or REPEAT, the edge where level falls goes to IDLE with the timer cleared. No pulse is emitted, even if a repeat expiry coincides on the same edge (release wins).
- Pulse timing: with a press accepted at edge t, pulses occur at t, t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- press_count increments on the same edge valid_pulse is set. It wraps modulo 256 with no saturation.
- valid_pulse is never high for two consecutive cycles.
- Reset mid-operation: all state returns to reset values. A button still held after rst deasserts is treated as a fresh press: pulse after DEBOUNCE_CYCLES+2 edges.
- All outputs are driven directly from flops; there are no combinational paths from button or repeat_en to outputs.

Test Plan:
Parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 throughout.
1. Clean press: rst for 3 cycles, then button=1 from edge 1, repeat_en=0 -> level and valid_pulse rise after edge 6; valid_pulse low after edge 7; press_count=1; no further pulses for 100 cycles held.
2. Bounce rejection: button toggles 1,0,1,0 at 2-cycle intervals, then 0 -> no pulse, level stays 0, press_count=0. Then bounce 3 times before holding 1 -> exactly one pulse, 6 edges after the last rising bounce.
3. Auto-repeat: repeat_en=1, hold 40 cycles after acceptance at edge t -> pulses at t, t+10, t+15, t+20, t+25, t+30, t+35, t+40; press_count=8. Release -> level falls 6 edges later, no pulse.
4. Release on expiry: arrange for level to fall on the same edge as t+15 -> no pulse at t+15; FSM returns to IDLE; press_count unchanged.
5. Reset mid-hold: in REPEAT, assert rst for 1 cycle with button held -> outputs 0 and press_count=0 after the reset edge; a new pulse 6 edges after rst deasserts.
6. Wrap: 256 accepted presses -> press_count returns to 0; each press produces exactly one single-cycle valid_pulse.
